// File: rtl/seg_write_sequencer_pkg.sv
// Shared types and sizing for the seven-segment write sequencer.
// One nibble per digit, digits addressed by a SEL_W-bit index.
package seg_seq_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int NIB_W      = 4;
  localparam int SEL_W      = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_DONE} state_t;
  typedef logic [NIB_W-1:0] nibble_t;

  function automatic nibble_t get_nibble(input logic [NUM_DIGITS*NIB_W-1:0] v,
                                         input logic [SEL_W-1:0] idx);
    return v[idx*NIB_W +: NIB_W];
  endfunction
endpackage

// File: rtl/seg_write_sequencer_if.sv
// Request handshake plus display write port between a value source and the sequencer.
// master = requester/display side, slave = the sequencer itself.
interface seg_write_sequencer_if import seg_seq_pkg::*; ();
  logic                        start;
  logic [NUM_DIGITS*NIB_W-1:0] value;
  logic [NUM_DIGITS-1:0]       digit_mask;
  logic                        busy;
  logic                        done;
  logic [SEL_W-1:0]            sel;
  nibble_t                     num;
  logic                        write;

  modport master (output start, value, digit_mask,
                  input  busy, done, sel, num, write);
  modport slave  (input  start, value, digit_mask,
                  output busy, done, sel, num, write);
endinterface

// File: rtl/seg_write_sequencer_lowest_set.sv
// Priority encoder: index of the lowest set bit of a NUM_DIGITS-wide mask.
// Purely combinational; valid is low when the mask is empty.
module seg_lowest_set import seg_seq_pkg::*; (
  input  logic [NUM_DIGITS-1:0] mask_i,
  output logic [SEL_W-1:0]      idx_o,
  output logic                  valid_o
);
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    // Scan downward so the lowest set bit is the last one to win.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o   = SEL_W'(i);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seg_write_sequencer.sv
// Streams a captured 8-digit image into the display unit, one write strobe per enabled digit.
// Outputs are registered; the first strobe appears the cycle after start is sampled.
module seg_write_sequencer import seg_seq_pkg::*; #(
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  seg_write_sequencer_if.slave  bus
);
  localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                      state_q, state_d;
  logic [NUM_DIGITS*NIB_W-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]       mask_q, mask_d;
  logic [3:0]                  gap_q, gap_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        write_q, write_d;
  logic [SEL_W-1:0]            sel_q, sel_d;
  nibble_t                     num_q, num_d;

  logic [NUM_DIGITS*NIB_W-1:0] src_val;
  logic [NUM_DIGITS-1:0]       src_mask;
  logic [NUM_DIGITS-1:0]       lo_bit;
  logic [SEL_W-1:0]            idx;
  logic                        idx_vld;
  logic                        issue;

  // In IDLE the first digit is encoded straight from the inputs so its strobe lands at T+1.
  assign src_val  = (state_q == S_IDLE) ? bus.value      : val_q;
  assign src_mask = (state_q == S_IDLE) ? bus.digit_mask : mask_q;
  assign lo_bit   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

  seg_lowest_set u_lowest (
    .mask_i  (src_mask),
    .idx_o   (idx),
    .valid_o (idx_vld)
  );

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    mask_d  = mask_q;
    gap_d   = gap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    write_d = 1'b0;
    sel_d   = sel_q;
    num_d   = num_q;
    issue   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          val_d  = bus.value;
          mask_d = bus.digit_mask;
          busy_d = 1'b1;
          if (idx_vld) begin
            issue   = 1'b1;
            state_d = S_WRITE;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        if (!idx_vld) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (GAP_CYCLES > 0) begin
          gap_d   = GAP_LAST;
          state_d = S_GAP;
        end else begin
          issue = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          issue   = 1'b1;
          state_d = S_WRITE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      write_d = 1'b1;
      sel_d   = idx;
      num_d   = get_nibble(src_val, idx);
      mask_d  = src_mask & ~lo_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      mask_q  <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      write_q <= 1'b0;
      sel_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      mask_q  <= mask_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      write_q <= write_d;
      sel_q   <= sel_d;
      num_q   <= num_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.write = write_q;
  assign bus.sel   = sel_q;
  assign bus.num   = num_q;
endmodule

// File: doc/seg_write_sequencer.md
Name: seg_write_sequencer

Overview:
Controller that loads a full 8-digit display image into the seven-segment display unit. It drives the unit's sel/num/write port one digit at a time.
- Takes a 32-bit packed value and an 8-bit digit mask on a start/busy/done handshake.
- Issues exactly one write pulse per enabled digit, in ascending digit order, with an optional fixed gap between pulses.
- Sits between the system's value source (switches, counter, CPU register) and the display unit, replacing hand-driven write pulses.

Parameters:
- NUM_DIGITS, 8, number of display digits; SEL_W = $clog2(NUM_DIGITS).
- NIB_W, 4, bits per digit value.
- GAP_CYCLES, 0, idle cycles inserted after each write pulse before the next (0..15).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- value  in  NUM_DIGITS*NIB_W (32)  packed digits; digit i = value[4i+3:4i].
- digit_mask  in  NUM_DIGITS (8)  bit i=1 means digit i is written.
- busy  out  1  high while a sequence is in progress, including the DONE cycle.
- done  out  1  one-cycle completion pulse.
- sel  out  SEL_W (3)  digit index to the display unit.
- num  out  NIB_W (4)  digit value to the display unit.
- write  out  1  one-cycle write strobe to the display unit.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low: reset low at a rising edge forces IDLE and all registered state to zero.
- Reset values: busy=0, done=0, write=0, sel=0, num=0; captured value, captured mask and gap counter all 0.
- Registered outputs: all outputs are registered. sel/num hold their last written values while write=0, and write alone qualifies them.
- States:
  - IDLE: on start=1 at edge T, capture value and digit_mask into internal registers.
    - Captured mask nonzero: go to WRITE.
    - Captured mask zero: go to DONE.
  - WRITE (1 cycle): outputs sel=idx, num=captured nibble[idx] and write=1, where idx is the lowest set bit of the remaining mask. That bit is then cleared.
    - Remaining mask now empty: go to DONE.
    - Otherwise, GAP_CYCLES>0: go to GAP.
    - Otherwise: stay in WRITE for the next digit.
  - GAP: count GAP_CYCLES cycles with write=0, then return to WRITE.
  - DONE (1 cycle): done=1, write=0, then return to IDLE.
- Timing for k enabled digits, start sampled at edge T:
  - j-th write (j=0..k-1) is visible in cycle T+1+j*(GAP_CYCLES+1).
  - done is visible in cycle T+1+(k-1)*(GAP_CYCLES+1)+1.
  - busy is high from T+1 through the done cycle.
  - Mask=0: done and busy are high in cycle T+1 only; no write occurs.
- Inputs during a sequence: start, value and digit_mask are ignored while busy=1, including the DONE cycle. A new start is accepted from the first IDLE cycle after done.
- Ordering and width:
  - Writes are strictly ascending by digit index; disabled digits cost zero cycles.
  - Every enabled digit is written exactly once per sequence.
  - num is taken from the captured value, never from the live value input.
- Reset mid-sequence: at the next edge with reset=0, write/busy/done drop to 0 and no further writes occur. A partially written image is acceptable.

Decomposition:
- Package seg_seq_pkg holds:
  - constants NUM_DIGITS, NIB_W, SEL_W;
  - typedef enum logic [1:0] state_t {S_IDLE, S_WRITE, S_GAP, S_DONE};
  - typedef logic [NIB_W-1:0] nibble_t.
- One combinational sub-module, seg_lowest_set, is natural: an NUM_DIGITS-bit priority encoder outputting idx[SEL_W-1:0] and valid.

Test Plan:
- Reset: hold reset=0 for 2 edges with start=1 -> busy=done=write=sel=num=0; no write pulse after reset releases until a new start.
- Full image, GAP=0: value=32'h8765_4321, mask=8'hFF, start at T -> writes in cycles T+1..T+8 with (sel,num)=(0,1),(1,2),...,(7,8); done at T+9; busy high T+1..T+9.
- Sparse mask: value=32'hFEDC_BA98, mask=8'b1010_0100 -> exactly 3 writes, (2,A),(5,D),(7,F), in T+1..T+3; done at T+4.
- Empty mask: mask=8'h00, start -> no write; done=1 and busy=1 in T+1 only; IDLE at T+2.
- Ignore while busy: start a full-mask sequence with 32'h1111_1111, then at T+3 pulse start with value=32'h9999_9999 -> all 8 writes carry num=1; exactly one done.
- GAP=2 instance plus reset: mask=8'hFF -> writes at T+1, T+4, T+7. Pull reset=0 for the edge ending cycle T+7 -> from T+8, write=busy=done=0; no further writes.
